lfsr_deal_gen: RTL and testbench

LFSR_DEAL_GEN -- requirements
Module: lfsr_deal_gen

---
 rtl/lfsr_deal_gen.sv | 141 ++++++++++++++
 tb/tb_lfsr_deal_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/lfsr_deal_gen.sv
// lfsr_deal_gen: fills a DEPTH-entry buffer with LFSR-derived values in 1..RANGE.
// Define LFSR_DEAL_UNIQUE_EN to reject repeated values (unique "deal" mode).
module lfsr_deal_gen #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hAC00,
    parameter int               RANGE = 52,
    parameter int               OUT_W = 6,
    parameter int               DEPTH = 200,
    parameter int               AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             seed_load,
    input  logic             start,
    input  logic [AW-1:0]    rd_addr,
    output logic [OUT_W-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      count
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [AW:0]      count_q, count_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [OUT_W-1:0] rd_data_q, rd_data_d;
    logic [OUT_W-1:0] mem_q [DEPTH];

    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [OUT_W-1:0] wr_data;
    logic [WIDTH-1:0] seed_fix, mod_v;
    logic [OUT_W-1:0] cand;
    logic             fb, accept;

    // Seed sanitising, feedback and candidate value from the pre-shift LFSR.
    always_comb begin
        seed_fix = (seed == '0) ? WIDTH'(1) : seed;
        fb       = ^(lfsr_q & TAPS);
        mod_v    = lfsr_q % WIDTH'(RANGE);
        cand     = OUT_W'(mod_v + WIDTH'(1));
    end

`ifdef LFSR_DEAL_UNIQUE_EN
    localparam int BW = (RANGE > 1) ? $clog2(RANGE) : 1;
    logic [RANGE-1:0] used_q, used_d;

    // A unique deal cannot produce more distinct values than the range holds.
    if (DEPTH > RANGE) begin : g_depth_chk
        $error("lfsr_deal_gen: unique mode needs DEPTH <= RANGE");
    end

    // Reject candidates already dealt in this fill.
    always_comb accept = ~used_q[mod_v[BW-1:0]];
`else
    // Every candidate is written when repeats are allowed.
    always_comb accept = 1'b1;
`endif

    // Next-state, LFSR, counter, buffer write and read-port logic.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = count_q[AW-1:0];
        wr_data = cand;
`ifdef LFSR_DEAL_UNIQUE_EN
        used_d  = used_q;
`endif
        case (state_q)
            FILL: begin
                lfsr_d = {lfsr_q[WIDTH-2:0], fb};
                if (accept) begin
                    wr_en   = 1'b1;
                    count_d = count_q + (AW+1)'(1);
`ifdef LFSR_DEAL_UNIQUE_EN
                    used_d[mod_v[BW-1:0]] = 1'b1;
`endif
                    if (count_d == DEPTH_C) state_d = DONE;
                end
            end
            default: begin
                // seed_load wins over start; start must be re-issued.
                if (seed_load) begin
                    lfsr_d = seed_fix;
                end else if (start) begin
                    state_d = FILL;
                    count_d = '0;
`ifdef LFSR_DEAL_UNIQUE_EN
                    used_d  = '0;
`endif
                end
            end
        endcase
        busy_d    = (state_d == FILL);
        done_d    = (state_d == DONE);
        rd_data_d = ({1'b0, rd_addr} < DEPTH_C) ? mem_q[rd_addr] : '0;
    end

    // Control registers; reset aborts any fill and reloads the seed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= seed_fix;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
        end
    end

`ifdef LFSR_DEAL_UNIQUE_EN
    // Used-value bitmap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) used_q <= '0;
        else     used_q <= used_d;
    end
`endif

    // Value buffer; contents survive reset and idle periods.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end

    assign rd_data = rd_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign count   = count_q;
endmodule

// File: tb/tb_lfsr_deal_gen.sv
// Directed bench for lfsr_deal_gen with a queue-based scoreboard.
module tb_lfsr_deal_gen;
    localparam int WIDTH = 16, RANGE = 52, OUT_W = 6, AW = 8;
`ifdef LFSR_DEAL_UNIQUE_EN
    localparam int DEP = 52;
`else
    localparam int DEP = 200;
`endif
    localparam logic [15:0] TB_TAPS = 16'hAC00;

    logic             clk = 1'b0;
    logic             rst, seed_load, start;
    logic [15:0]      seed;
    logic [AW-1:0]    rd_addr;
    logic [OUT_W-1:0] rd_data;
    logic             busy, done;
    logic [AW:0]      count;

    int n_pass = 0, n_tot = 0;
    int ncyc;
    logic [OUT_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    lfsr_deal_gen #(.WIDTH(WIDTH), .TAPS(TB_TAPS), .RANGE(RANGE), .OUT_W(OUT_W),
                    .DEPTH(DEP), .AW(AW)) dut (
        .clk(clk), .rst(rst), .seed(seed), .seed_load(seed_load), .start(start),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Reference deal: pushes the expected buffer and returns the fill length in cycles.
    task automatic push_fill(input logic [15:0] s, output int cyc);
        logic [15:0]      l;
        logic [RANGE-1:0] used;
        logic [OUT_W-1:0] c;
        int               n;
        l = (s == 16'h0) ? 16'h1 : s;
        used = '0;
        n = 0;
        cyc = 0;
        while (n < DEP && cyc < 20000) begin
            c = OUT_W'(l % RANGE + 1);
`ifdef LFSR_DEAL_UNIQUE_EN
            if (!used[c-1]) begin
                used[c-1] = 1'b1;
                exp_q.push_back(c);
                n++;
            end
`else
            exp_q.push_back(c);
            n++;
`endif
            l = {l[14:0], ^(l & TB_TAPS)};
            cyc++;
        end
    endtask

    task automatic run_fill(input string tag, input int exp_cyc, input bit repulse, input bit sload);
        int cyc = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_cnt0"}, count, 0);
        while (!done && cyc < 5000) begin
            if (repulse) start = (cyc == 50);
            if (sload) begin
                seed_load = (cyc == 20);
                seed      = 16'h5A5A;
            end
            @(negedge clk);
            cyc++;
            if (cyc == 10) chk({tag, "_done_lo"}, done, 0);
        end
        start = 1'b0;
        seed_load = 1'b0;
        chk({tag, "_cycles"}, cyc, exp_cyc);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_lo"}, busy, 0);
        chk({tag, "_count"}, count, DEP);
    endtask

    task automatic read_check(input string tag, input bit lit);
        logic [OUT_W-1:0] e;
        logic [OUT_W-1:0] k7 [7] = '{2, 3, 5, 9, 17, 33, 13};
        logic [63:0]      seen = '0;
        for (int a = 0; a < DEP; a++) begin
            @(negedge clk); rd_addr = AW'(a);
            @(posedge clk); #1;
            chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            chk(tag, rd_data, e);
`ifndef LFSR_DEAL_UNIQUE_EN
            if (lit && a < 7) chk({tag, "_lit"}, rd_data, k7[a]);
`else
            chk({tag, "_perm_range"}, (rd_data >= 1 && rd_data <= RANGE), 1);
            chk({tag, "_perm_dup"}, seen[rd_data], 0);
            seen[rd_data] = 1'b1;
`endif
        end
        @(negedge clk); rd_addr = AW'(DEP);
        @(posedge clk); #1;
        chk({tag, "_oob_depth"}, rd_data, 0);
        @(negedge clk); rd_addr = '1;
        @(posedge clk); #1;
        chk({tag, "_oob_max"}, rd_data, 0);
    endtask

    initial begin
        int w;
        rst = 1'b1; seed = 16'h0001; seed_load = 1'b0; start = 1'b0; rd_addr = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_rd", rd_data, 0);
        @(negedge clk); rst = 1'b0;

        // Seed 1, with a start re-pulse in the middle of the fill.
        push_fill(16'h0001, ncyc);
        run_fill("fill1", ncyc, 1'b1, 1'b0);
        read_check("rd1", 1'b1);

        // Seed 0 behaves as seed 1.
        @(negedge clk); seed = 16'h0000; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        push_fill(16'h0000, ncyc);
        run_fill("fill0", ncyc, 1'b0, 1'b0);
        read_check("rd0", 1'b1);

        // Abort a fill halfway with an asynchronous reset.
        @(negedge clk); seed = 16'hBEEF; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        w = 0;
        while (count != (AW+1)'(DEP/2) && w < 5000) begin
            @(negedge clk); w++;
        end
        chk("abort_reach", count, DEP/2);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_count", count, 0);
        chk("abort_rd", rd_data, 0);
        @(negedge clk); rst = 1'b0;
        // Refill from address 0; a seed_load mid-fill must be ignored.
        push_fill(16'hBEEF, ncyc);
        run_fill("fill_ab", ncyc, 1'b0, 1'b1);
        read_check("rd_ab", 1'b0);

        // In DONE: seed_load together with start defers the start.
        @(negedge clk); seed = 16'h1234; seed_load = 1'b1; start = 1'b1;
        @(negedge clk); seed_load = 1'b0; start = 1'b0;
        chk("defer_done", done, 1);
        chk("defer_busy", busy, 0);
        chk("defer_count", count, DEP);
        push_fill(16'h1234, ncyc);
        run_fill("fill_sl", ncyc, 1'b0, 1'b0);
        read_check("rd_sl", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
